// File: rtl/generar_ficha_if.sv
// generar_ficha_if
//   Bundles the spawn request, its operands and the spawn result between the
//   game controller side (master) and the tile spawner (slave).
//
//   Handshake: start is a one-cycle (or held) request. The slave samples it
//   only while idle. There is no ready signal; a start seen while busy=1 is
//   dropped, not queued. Completion is a single-cycle done pulse. While done=1,
//   matriz_salida is valid and sin_espacio tells whether the board was left
//   unchanged. The operands are captured on the accepting edge, so the master
//   may change them freely afterwards.
//
//   Signals
//     start           master->slave  spawn request
//     matriz_entrada  master->slave  board [row][col], 0 = empty cell
//     lista           master->slave  empty-cell indices (4*row+col)
//     contador        master->slave  number of valid entries in lista (signed)
//     matriz_salida   slave->master  board after spawn, held between operations
//     busy            slave->master  operation in flight
//     done            slave->master  one-cycle completion pulse
//     sin_espacio     slave->master  pulses with done when nothing was written
`timescale 1ns/1ps
interface generar_ficha_if;
  logic                       start;
  logic [3:0][3:0][31:0]      matriz_entrada;
  logic [15:0][31:0]          lista;
  logic signed [31:0]         contador;
  logic [3:0][3:0][31:0]      matriz_salida;
  logic                       busy;
  logic                       done;
  logic                       sin_espacio;

  modport master (
    output start, matriz_entrada, lista, contador,
    input  matriz_salida, busy, done, sin_espacio
  );

  modport slave (
    input  start, matriz_entrada, lista, contador,
    output matriz_salida, busy, done, sin_espacio
  );
endinterface

// File: rtl/generar_ficha.sv
// generar_ficha
//   Spawns a new 2 or 4 tile on the 4x4 board. The cell is picked
//   pseudo-randomly from the empty-cell list supplied by the upstream finder,
//   using a free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
//
//   Ports
//     clk          clock, rising edge
//     rst_n        asynchronous active-low reset
//     bus          generar_ficha_if.slave (start/operands in, result out)
//     o_dbg_state  current FSM state
//     o_dbg_lfsr   current LFSR value
`timescale 1ns/1ps
module generar_ficha #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [3:0]  P4_THRESH = 4'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  generar_ficha_if.slave    bus,
  output logic [2:0]        o_dbg_state,
  output logic [15:0]       o_dbg_lfsr
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CAPTURA  = 3'd1,
    S_ELEGIR   = 3'd2,
    S_ESCRIBIR = 3'd3,
    S_FIN      = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [15:0]           r_lfsr;
  logic                  w_fb;

  logic [3:0][3:0][31:0] r_matriz;
  logic [15:0][31:0]     r_lista;
  logic signed [31:0]    r_contador;
  logic [4:0]            r_cnt;
  logic [3:0]            r_pos;
  logic                  r_pos_ok;
  logic                  r_es4;
  logic                  r_sin_pend;
  logic [3:0][3:0][31:0] r_mat_sal;
  logic                  r_done;
  logic                  r_sin;

  logic [4:0]            w_cnt;
  logic [4:0]            w_div;
  logic [3:0]            w_sel;
  logic [31:0]           w_pos_raw;
  logic [31:0]           w_valor;
  logic                  w_write_ok;

  // LFSR runs every cycle, independent of the FSM. A zero value would lock
  // it up, so it reloads the seed instead.
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_lfsr <= SEED;
    else if (r_lfsr == 16'd0) r_lfsr <= SEED;
    else                     r_lfsr <= {w_fb, r_lfsr[15:1]};
  end

  // Count clamp: negative or zero means no space, above 16 is saturated.
  always_comb begin
    w_cnt = 5'd0;
    if (r_contador <= 0)       w_cnt = 5'd0;
    else if (r_contador > 16)  w_cnt = 5'd16;
    else                       w_cnt = r_contador[4:0];
  end

  // Divisor forced nonzero outside ELEGIR so the modulo never divides by 0.
  assign w_div      = (r_cnt == 5'd0) ? 5'd1 : r_cnt;
  assign w_sel      = 4'(r_lfsr[7:0] % {3'b000, w_div});
  assign w_pos_raw  = r_lista[w_sel];
  assign w_valor    = r_es4 ? 32'd4 : 32'd2;
  assign w_write_ok = r_pos_ok && (r_matriz[r_pos[3:2]][r_pos[1:0]] == 32'd0);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.start) w_next = S_CAPTURA;
      S_CAPTURA:  w_next = (w_cnt == 5'd0) ? S_FIN : S_ELEGIR;
      S_ELEGIR:   w_next = S_ESCRIBIR;
      S_ESCRIBIR: w_next = S_FIN;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Datapath. done/sin_espacio are registered on the edge leaving FIN, so the
  // pulse coincides with the first idle cycle and busy already low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_matriz   <= '0;
      r_lista    <= '0;
      r_contador <= '0;
      r_cnt      <= '0;
      r_pos      <= '0;
      r_pos_ok   <= 1'b0;
      r_es4      <= 1'b0;
      r_sin_pend <= 1'b0;
      r_mat_sal  <= '0;
      r_done     <= 1'b0;
      r_sin      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_sin  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_matriz   <= bus.matriz_entrada;
            r_lista    <= bus.lista;
            r_contador <= bus.contador;
            r_sin_pend <= 1'b0;
          end
        end
        S_CAPTURA: begin
          r_cnt <= w_cnt;
          if (w_cnt == 5'd0) begin
            r_mat_sal  <= r_matriz;
            r_sin_pend <= 1'b1;
          end
        end
        S_ELEGIR: begin
          // Unsigned compare also rejects negative indices.
          r_pos    <= w_pos_raw[3:0];
          r_pos_ok <= (w_pos_raw < 32'd16);
          r_es4    <= (r_lfsr[15:12] < P4_THRESH);
        end
        S_ESCRIBIR: begin
          r_mat_sal <= r_matriz;
          if (w_write_ok) r_mat_sal[r_pos[3:2]][r_pos[1:0]] <= w_valor;
          else            r_sin_pend <= 1'b1;
        end
        S_FIN: begin
          r_done <= 1'b1;
          r_sin  <= r_sin_pend;
        end
        default: ;
      endcase
    end
  end

  assign bus.matriz_salida = r_mat_sal;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = r_done;
  assign bus.sin_espacio   = r_sin;
  assign o_dbg_state       = r_state;
  assign o_dbg_lfsr        = r_lfsr;

endmodule
